// File: rtl/hiscore_ram_responder.sv
// RAM-side responder for the hiscore engine: it slips hiscore reads and writes into work-RAM
// cycles the CPU leaves free. Optional window filtering is enabled with `define HS_RANGE_CHECK_EN.
module hiscore_ram_responder #(
   parameter int          ADDR_W  = 11,
   parameter logic [15:0] HS_BASE = 16'h6000,
   parameter int          HS_SIZE = 2048
) (
   input  logic              clk_sys,
   input  logic              reset,
   // CPU work-RAM port
   input  logic              cpu_ce,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   // hiscore engine access interface
   input  logic [15:0]       hs_address,
   input  logic [7:0]        hs_data_in,
   input  logic              hs_write_enable,
   input  logic              hs_read_intent,
   input  logic              hs_write_intent,
   output logic [7:0]        hs_data_out,
   output logic              hs_ack,
   // single-port synchronous RAM
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_din,
   input  logic [7:0]        ram_dout
);

   typedef enum logic [1:0] {IDLE, RDWAIT, DONE, GAP} state_t;

   state_t            state;
   logic              cpu_rd_d;
   logic              hs_rd_d;
   logic              rd_oor;
   logic [ADDR_W-1:0] hs_local;
   logic              hs_in_win;
   logic              hs_wr_req;
   logic              hs_req;
   logic              hs_issue;
   logic              hs_ram;

   assign hs_local = ADDR_W'(hs_address - HS_BASE);

`ifdef HS_RANGE_CHECK_EN
   logic [16:0] win_lo;
   logic [16:0] win_hi;
   assign win_lo    = {1'b0, HS_BASE};
   assign win_hi    = win_lo + 17'(HS_SIZE);
   assign hs_in_win = ({1'b0, hs_address} >= win_lo) && ({1'b0, hs_address} < win_hi);
`else
   // Out-of-window addresses simply wrap into the RAM.
   assign hs_in_win = 1'b1;
`endif

   // A write needs both the intent and the enable; otherwise a read intent wins.
   assign hs_wr_req = hs_write_intent & hs_write_enable;
   assign hs_req    = hs_read_intent | hs_wr_req;
   assign hs_issue  = (state == IDLE) & ~cpu_ce & ~reset & hs_req;
   assign hs_ram    = hs_issue & hs_in_win;

   always_comb begin
      ram_addr = cpu_addr;
      ram_we   = 1'b0;
      ram_din  = cpu_din;
      if (cpu_ce) begin
         ram_we = cpu_we & ~reset;
      end else if (hs_ram) begin
         ram_addr = hs_local;
         ram_we   = hs_wr_req;
         ram_din  = hs_data_in;
      end
   end

   // CPU read data: RAM output is valid one cycle after the address.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cpu_rd_d <= 1'b0;
         cpu_dout <= 8'h00;
      end else begin
         cpu_rd_d <= cpu_ce & ~cpu_we;
         if (cpu_rd_d) cpu_dout <= ram_dout;
      end
   end

   // Capture happens in RDWAIT regardless of cpu_ce: the RAM read was launched a cycle
   // earlier, so a CPU access now only affects the next cycle's ram_dout.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= IDLE;
         hs_ack      <= 1'b0;
         hs_data_out <= 8'h00;
         hs_rd_d     <= 1'b0;
         rd_oor      <= 1'b0;
      end else begin
         hs_ack  <= 1'b0;
         hs_rd_d <= 1'b0;
         case (state)
            IDLE: begin
               if (hs_issue) begin
                  if (hs_wr_req) begin
                     state <= DONE;
                  end else begin
                     state   <= RDWAIT;
                     hs_rd_d <= 1'b1;
                     rd_oor  <= ~hs_in_win;
                  end
               end
            end
            RDWAIT: begin
               hs_data_out <= rd_oor ? 8'h00 : ram_dout;
               hs_ack      <= 1'b1;
               state       <= GAP;
            end
            DONE: begin
               hs_ack <= 1'b1;
               state  <= GAP;
            end
            // One dead cycle so a still-held intent is not issued twice.
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hiscore_ram_responder.sv
// Directed bench for hiscore_ram_responder with a behavioural synchronous RAM.
// Expectations follow HS_RANGE_CHECK_EN when the bench is built with that define.
module tb_hiscore_ram_responder;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        cpu_ce, cpu_we;
   logic [10:0] cpu_addr;
   logic [7:0]  cpu_din, cpu_dout;
   logic [15:0] hs_address;
   logic [7:0]  hs_data_in, hs_data_out;
   logic        hs_write_enable, hs_read_intent, hs_write_intent, hs_ack;
   logic [10:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_din, ram_dout;

   int n_chk  = 0;
   int n_fail = 0;
   int we_cnt = 0;

   always #5 clk_sys = ~clk_sys;

   hiscore_ram_responder dut (
      .clk_sys(clk_sys), .reset(reset),
      .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout),
      .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write_enable(hs_write_enable),
      .hs_read_intent(hs_read_intent), .hs_write_intent(hs_write_intent),
      .hs_data_out(hs_data_out), .hs_ack(hs_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // Read-first synchronous single-port RAM.
   logic [7:0] mem [0:2047];
   always @(posedge clk_sys) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   always @(posedge clk_sys) if (ram_we) we_cnt <= we_cnt + 1;

   typedef struct {
      bit          ce, we;
      logic [10:0] caddr;
      logic [7:0]  cdin;
      logic [15:0] haddr;
      logic [7:0]  hdin;
      bit          wen, rd, wr;
      logic [10:0] e_addr;
      bit          e_we;
      logic [7:0]  e_din;
      int          e_acks;
      bit          chk_data;
      logic [7:0]  e_data;
   } vec_t;

   function automatic vec_t mk(bit ce, bit we, logic [10:0] caddr, logic [7:0] cdin,
                               logic [15:0] haddr, logic [7:0] hdin, bit wen, bit rd, bit wr,
                               logic [10:0] e_addr, bit e_we, logic [7:0] e_din, int e_acks,
                               bit chk_data, logic [7:0] e_data);
      vec_t v;
      v.ce = ce; v.we = we; v.caddr = caddr; v.cdin = cdin;
      v.haddr = haddr; v.hdin = hdin; v.wen = wen; v.rd = rd; v.wr = wr;
      v.e_addr = e_addr; v.e_we = e_we; v.e_din = e_din; v.e_acks = e_acks;
      v.chk_data = chk_data; v.e_data = e_data;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle_in();
      cpu_ce = 0; cpu_we = 0;
      hs_read_intent = 0; hs_write_intent = 0; hs_write_enable = 0;
   endtask

   task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
      cpu_ce = 1; cpu_we = 1; cpu_addr = a; cpu_din = d;
      tick();
      idle_in();
   endtask

   vec_t tv [9];

   initial begin
      int acks, w0;

      tv[0] = mk(1, 1, 11'h055, 8'h11, 16'h6123, 8'h00, 0, 1, 0, 11'h055, 1, 8'h11, 0, 0, 8'h00);
      tv[1] = mk(0, 0, 11'h3C0, 8'h00, 16'h6123, 8'h00, 0, 1, 0, 11'h123, 0, 8'h00, 1, 1, 8'h5A);
      tv[2] = mk(0, 0, 11'h3C0, 8'h00, 16'h6010, 8'hC3, 1, 0, 1, 11'h010, 1, 8'hC3, 1, 0, 8'h00);
      tv[3] = mk(0, 0, 11'h077, 8'h00, 16'h6123, 8'h00, 0, 0, 0, 11'h077, 0, 8'h00, 0, 0, 8'h00);
      tv[4] = mk(0, 0, 11'h033, 8'h00, 16'h6300, 8'h55, 0, 0, 1, 11'h033, 0, 8'h00, 0, 0, 8'h00);
      tv[5] = mk(0, 0, 11'h033, 8'h00, 16'h6200, 8'h55, 0, 1, 1, 11'h200, 0, 8'h00, 1, 1, 8'h21);
      tv[6] = mk(0, 0, 11'h033, 8'h00, 16'h6201, 8'h99, 1, 1, 1, 11'h201, 1, 8'h99, 1, 0, 8'h00);
`ifdef HS_RANGE_CHECK_EN
      tv[7] = mk(0, 0, 11'h7FF, 8'h00, 16'h5FFF, 8'h00, 0, 1, 0, 11'h7FF, 0, 8'h00, 1, 1, 8'h00);
      tv[8] = mk(0, 0, 11'h0AA, 8'h00, 16'h6800, 8'h44, 1, 0, 1, 11'h0AA, 0, 8'h00, 1, 0, 8'h00);
`else
      tv[7] = mk(0, 0, 11'h7FF, 8'h00, 16'h5FFF, 8'h00, 0, 1, 0, 11'h7FF, 0, 8'h00, 1, 1, 8'hEE);
      tv[8] = mk(0, 0, 11'h0AA, 8'h00, 16'h6800, 8'h44, 1, 0, 1, 11'h000, 1, 8'h44, 1, 0, 8'h00);
`endif

      reset = 1; idle_in();
      cpu_addr = 0; cpu_din = 0; hs_address = 0; hs_data_in = 0;
      repeat (3) tick();
      chk("reset_cpu_dout", cpu_dout, 0);
      chk("reset_hs_data_out", hs_data_out, 0);
      chk("reset_hs_ack", hs_ack, 0);
      chk("reset_ram_we", ram_we, 0);
      reset = 0;

      cpu_write(11'h123, 8'h5A);
      cpu_write(11'h055, 8'h11);
      cpu_write(11'h200, 8'h21);
      cpu_write(11'h066, 8'h77);
      cpu_write(11'h7FF, 8'hEE);
      tick();

      // Table: RAM mux from IDLE, then ack count and read data over the following cycles.
      for (int i = 0; i < 9; i++) begin
         cpu_ce = tv[i].ce; cpu_we = tv[i].we; cpu_addr = tv[i].caddr; cpu_din = tv[i].cdin;
         hs_address = tv[i].haddr; hs_data_in = tv[i].hdin; hs_write_enable = tv[i].wen;
         hs_read_intent = tv[i].rd; hs_write_intent = tv[i].wr;
         #1;
         chk($sformatf("v%0d_ram_addr", i), ram_addr, tv[i].e_addr);
         chk($sformatf("v%0d_ram_we", i), ram_we, tv[i].e_we);
         if (tv[i].e_we) chk($sformatf("v%0d_ram_din", i), ram_din, tv[i].e_din);
         tick();
         idle_in();
         acks = 0;
         for (int c = 0; c < 4; c++) begin
            if (hs_ack) begin
               acks++;
               if (tv[i].chk_data) chk($sformatf("v%0d_hs_data", i), hs_data_out, tv[i].e_data);
            end
            tick();
         end
         chk($sformatf("v%0d_acks", i), acks, tv[i].e_acks);
      end

      // Read latency and GAP spacing with the intent held.
      cpu_addr = 11'h3C0; hs_address = 16'h6123; hs_read_intent = 1;
      #1 chk("lat_issue_addr", ram_addr, 11'h123);
      tick(); chk("lat_n1_ack", hs_ack, 0); chk("lat_n1_addr", ram_addr, 11'h3C0);
      tick(); chk("lat_n2_ack", hs_ack, 1); chk("lat_n2_data", hs_data_out, 8'h5A);
      chk("lat_gap_addr", ram_addr, 11'h3C0);
      tick(); chk("lat_n3_ack", hs_ack, 0); chk("lat_reissue_addr", ram_addr, 11'h123);
      tick(); chk("lat_n4_ack", hs_ack, 0);
      tick(); chk("lat_n5_ack", hs_ack, 1);
      hs_read_intent = 0;
      tick(); chk("lat_n6_ack", hs_ack, 0);

      // Intent dropped after issue still completes.
      hs_address = 16'h6200; hs_read_intent = 1;
      tick(); hs_read_intent = 0;
      tick(); chk("drop_ack", hs_ack, 1); chk("drop_data", hs_data_out, 8'h21);
      tick(); tick();

      // Write: exactly one RAM write cycle, ack, then CPU reads it back.
      w0 = we_cnt;
      hs_address = 16'h6010; hs_data_in = 8'hC3; hs_write_intent = 1; hs_write_enable = 1;
      #1 chk("wr_ram_addr", ram_addr, 11'h010);
      tick(); idle_in();
      chk("wr_n1_we", ram_we, 0); chk("wr_n1_ack", hs_ack, 0);
      tick(); chk("wr_ack", hs_ack, 1); chk("wr_we_cycles", we_cnt - w0, 1);
      tick();
      cpu_ce = 1; cpu_addr = 11'h010;
      tick(); idle_in();
      tick(); chk("wr_cpu_readback", cpu_dout, 8'hC3);

      // Contention: CPU holds the RAM for 5 cycles.
      cpu_ce = 1; cpu_we = 0; cpu_addr = 11'h055; hs_address = 16'h6123; hs_read_intent = 1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("cont_addr%0d", c), ram_addr, 11'h055);
         chk($sformatf("cont_ack%0d", c), hs_ack, 0);
         tick();
      end
      chk("cont_cpu_dout", cpu_dout, 8'h11);
      cpu_ce = 0;
      #1 chk("cont_issue_addr", ram_addr, 11'h123);
      tick(); chk("cont_n1_ack", hs_ack, 0);
      hs_read_intent = 0;
      tick(); chk("cont_ack", hs_ack, 1); chk("cont_data", hs_data_out, 8'h5A);
      tick();

      // Pipelined overlap: hs read then CPU read on the next cycle.
      hs_address = 16'h6200; hs_read_intent = 1;
      tick(); hs_read_intent = 0; cpu_ce = 1; cpu_addr = 11'h066;
      #1 chk("ovl_cpu_addr", ram_addr, 11'h066);
      tick(); cpu_ce = 0;
      chk("ovl_ack", hs_ack, 1); chk("ovl_hs_data", hs_data_out, 8'h21);
      tick(); chk("ovl_cpu_dout", cpu_dout, 8'h77);
      chk("ovl_hs_hold", hs_data_out, 8'h21);
      tick();

      // Reset during RDWAIT.
      hs_address = 16'h6123; hs_read_intent = 1;
      tick(); reset = 1;
      tick();
      chk("rst_ack", hs_ack, 0); chk("rst_hs_data", hs_data_out, 0);
      chk("rst_cpu_dout", cpu_dout, 0); chk("rst_ram_we", ram_we, 0);
      reset = 0;
      #1 chk("rst_idle_issue", ram_addr, 11'h123);
      tick(); hs_read_intent = 0;
      tick(); chk("rst_after_ack", hs_ack, 1); chk("rst_after_data", hs_data_out, 8'h5A);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
